// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, select codes, ALU functions, FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_LUI  = 3'd4;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_RA    = 2'b10;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_DM   = 2'b01;
  localparam logic [1:0] M2R_PC4  = 2'b10;
  localparam logic [1:0] M2R_SLT  = 2'b11;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  typedef enum logic [3:0] {
    CLS_ADDU, CLS_SUBU, CLS_SLT, CLS_ORI, CLS_LUI, CLS_LW,
    CLS_SW, CLS_BEQ, CLS_J, CLS_JAL, CLS_JR, CLS_ILLEGAL
  } insn_cls_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  typedef struct packed {
    insn_cls_t  cls;
    logic [2:0] alu_op;
    logic       ext_op;
    logic       alu_src;
    logic [1:0] reg_dst;
  } dec_t;

endpackage

// File: rtl/insn_decode.sv
// Combinational instruction classifier: instr -> class plus the static ALU/extend/operand/destination selects.
module insn_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    dec = '{cls: CLS_ILLEGAL, alu_op: ALU_ADD, ext_op: 1'b1, alu_src: 1'b0, reg_dst: RD_RT};
    case (opcode)
      OP_RTYPE: begin
        dec.reg_dst = RD_RD;
        case (funct)
          FN_ADDU: dec.cls = CLS_ADDU;
          FN_SUBU: begin
            dec.cls    = CLS_SUBU;
            dec.alu_op = ALU_SUB;
          end
          FN_SLT: begin
            dec.cls    = CLS_SLT;
            dec.alu_op = ALU_SLT;
          end
          FN_JR:   dec.cls = CLS_JR;
          default: dec.cls = CLS_ILLEGAL;
        endcase
      end
      OP_ORI: begin
        dec.cls     = CLS_ORI;
        dec.alu_op  = ALU_OR;
        dec.ext_op  = 1'b0;
        dec.alu_src = 1'b1;
      end
      OP_LUI: begin
        dec.cls     = CLS_LUI;
        dec.alu_op  = ALU_LUI;
        dec.alu_src = 1'b1;
      end
      OP_LW: begin
        dec.cls     = CLS_LW;
        dec.alu_src = 1'b1;
      end
      OP_SW: begin
        dec.cls     = CLS_SW;
        dec.alu_src = 1'b1;
      end
      OP_BEQ: begin
        dec.cls    = CLS_BEQ;
        dec.alu_op = ALU_SUB;
      end
      OP_J:    dec.cls = CLS_J;
      OP_JAL: begin
        dec.cls     = CLS_JAL;
        dec.reg_dst = RD_RA;
      end
      default: dec.cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB per instruction, IM/DM wait-states with timeout,
// sticky halt on illegal opcode or bus timeout, and a wrapping retired-instruction counter.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic [8:0]       zero,
  input  logic             im_ready,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ir_en,
  output logic [1:0]       RegDst,
  output logic             AluSrc,
  output logic [1:0]       MemToReg,
  output logic [1:0]       PCsrc,
  output logic             ExtOp,
  output logic             we,
  output logic [2:0]       AluOp,
  output logic             memread,
  output logic             memwrite,
  output logic             slt_real,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  state_t            state;
  state_t            state_nxt;
  dec_t              dec;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_inc;
  logic              wait_expired;
  logic              set_bus_err;
  logic              unused_zero;

  insn_decode u_dec (
    .instr (instr),
    .dec   (dec)
  );

  assign unused_zero = ^{zero[8:5], zero[2:0]};

  // The counter holds the number of cycles already waited; ready on the last allowed cycle still wins.
  assign wait_expired = (WAIT_MAX != 0) && (wait_cnt == WAIT_W'(WAIT_MAX - 1));

  assign halted = (state == ST_HALT);

  always_comb begin
    state_nxt   = state;
    pc_en       = 1'b0;
    ir_en       = 1'b0;
    RegDst      = RD_RT;
    AluSrc      = 1'b0;
    MemToReg    = M2R_ALU;
    PCsrc       = PC_PLUS4;
    ExtOp       = 1'b0;
    we          = 1'b0;
    AluOp       = ALU_ADD;
    memread     = 1'b0;
    memwrite    = 1'b0;
    wait_inc    = 1'b0;
    set_bus_err = 1'b0;

    case (state)
      ST_IDLE: state_nxt = ST_FETCH;

      ST_FETCH: begin
        if (im_ready) begin
          ir_en     = 1'b1;
          state_nxt = ST_DECODE;
        end else if (wait_expired) begin
          set_bus_err = 1'b1;
          state_nxt   = ST_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end

      ST_DECODE: state_nxt = (dec.cls == CLS_ILLEGAL) ? ST_HALT : ST_EXEC;

      ST_EXEC: begin
        AluOp  = dec.alu_op;
        AluSrc = dec.alu_src;
        ExtOp  = dec.ext_op;
        case (dec.cls)
          CLS_BEQ: begin
            pc_en     = 1'b1;
            PCsrc     = zero[4] ? PC_BRANCH : PC_PLUS4;
            state_nxt = ST_FETCH;
          end
          CLS_J: begin
            pc_en     = 1'b1;
            PCsrc     = PC_JUMP;
            state_nxt = ST_FETCH;
          end
          CLS_JR: begin
            pc_en     = 1'b1;
            PCsrc     = PC_RS;
            state_nxt = ST_FETCH;
          end
          CLS_JAL: begin
            pc_en     = 1'b1;
            PCsrc     = PC_JUMP;
            we        = 1'b1;
            RegDst    = dec.reg_dst;
            MemToReg  = M2R_PC4;
            state_nxt = ST_FETCH;
          end
          CLS_LW, CLS_SW: state_nxt = ST_MEM;
          default:        state_nxt = ST_WB;
        endcase
      end

      ST_MEM: begin
        AluOp    = dec.alu_op;
        AluSrc   = 1'b1;
        ExtOp    = 1'b1;
        memread  = (dec.cls == CLS_LW);
        memwrite = (dec.cls == CLS_SW);
        if (mem_ready) begin
          if (dec.cls == CLS_SW) begin
            pc_en     = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_WB;
          end
        end else if (wait_expired) begin
          set_bus_err = 1'b1;
          state_nxt   = ST_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end

      ST_WB: begin
        AluOp     = dec.alu_op;
        AluSrc    = dec.alu_src;
        ExtOp     = dec.ext_op;
        we        = 1'b1;
        pc_en     = 1'b1;
        RegDst    = dec.reg_dst;
        if (dec.cls == CLS_LW)       MemToReg = M2R_DM;
        else if (dec.cls == CLS_SLT) MemToReg = M2R_SLT;
        else                         MemToReg = M2R_ALU;
        state_nxt = ST_FETCH;
      end

      ST_HALT: state_nxt = ST_HALT;

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      // Any state change restarts the wait budget, so every FETCH/MEM entry starts from zero.
      if (state_nxt != state) wait_cnt <= '0;
      else if (wait_inc)      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_err  <= 1'b0;
      slt_real <= 1'b0;
      instret  <= '0;
    end else begin
      if (set_bus_err) bus_err <= 1'b1;
      if (state == ST_EXEC && dec.cls == CLS_SLT) slt_real <= zero[3];
      if (pc_en) instret <= instret + 1'b1;
    end
  end

  a_halt_quiet: assert property (@(posedge clk) disable iff (!reset)
    halted |-> !(pc_en || ir_en || we || memread || memwrite));
  a_rw_exclusive: assert property (@(posedge clk) disable iff (!reset) !(memread && memwrite));
  a_err_halts: assert property (@(posedge clk) disable iff (!reset) bus_err |-> halted);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench: per-instruction latency/strobe/select expectations from an ISA-level model.
module tb_multicycle_ctrl;
  import mips_pkg::*;

  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 6;

  typedef enum int {K_ADDU, K_SUBU, K_SLT, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR} kind_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [31:0]      instr = '0;
  logic [8:0]       zero = '0;
  logic             im_ready = 1'b0;
  logic             mem_ready = 1'b0;
  logic             pc_en, ir_en, AluSrc, ExtOp, we, memread, memwrite, slt_real, halted, bus_err;
  logic [1:0]       RegDst, MemToReg, PCsrc;
  logic [2:0]       AluOp;
  logic [CNT_W-1:0] instret;

  int          vecs = 0;
  int          errs = 0;
  int unsigned model_instret = 0;
  logic        model_slt = 1'b0;

  multicycle_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .im_ready(im_ready), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_en(ir_en), .RegDst(RegDst), .AluSrc(AluSrc), .MemToReg(MemToReg), .PCsrc(PCsrc),
    .ExtOp(ExtOp), .we(we), .AluOp(AluOp), .memread(memread), .memwrite(memwrite), .slt_real(slt_real),
    .halted(halted), .bus_err(bus_err), .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] encode(kind_t k);
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    rs  = 5'($urandom);
    rt  = 5'($urandom);
    rd  = 5'($urandom);
    imm = 16'($urandom);
    tgt = 26'($urandom);
    case (k)
      K_ADDU:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      K_SUBU:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      K_SLT:   return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      K_JR:    return {6'h00, rs, 15'd0, 6'h08};
      K_ORI:   return {6'h0D, rs, rt, imm};
      K_LUI:   return {6'h0F, 5'd0, rt, imm};
      K_LW:    return {6'h23, rs, rt, imm};
      K_SW:    return {6'h2B, rs, rt, imm};
      K_BEQ:   return {6'h04, rs, rt, imm};
      K_J:     return {6'h02, tgt};
      default: return {6'h03, tgt};
    endcase
  endfunction

  function automatic int exp_lat(kind_t k, int imw, int mw);
    case (k)
      K_BEQ, K_J, K_JAL, K_JR: return imw + 3;
      K_LW:                    return imw + mw + 5;
      K_SW:                    return imw + mw + 4;
      default:                 return imw + 4;
    endcase
  endfunction

  function automatic logic [1:0] exp_pcsrc(kind_t k, logic z4);
    case (k)
      K_BEQ:      return z4 ? 2'b01 : 2'b00;
      K_J, K_JAL: return 2'b10;
      K_JR:       return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] exp_regdst(kind_t k);
    if (k == K_ADDU || k == K_SUBU || k == K_SLT) return 2'b01;
    if (k == K_JAL) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [1:0] exp_m2r(kind_t k);
    if (k == K_LW)  return 2'b01;
    if (k == K_SLT) return 2'b11;
    if (k == K_JAL) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [2:0] exp_aluop(kind_t k);
    case (k)
      K_SUBU:  return ALU_SUB;
      K_SLT:   return ALU_SLT;
      K_ORI:   return ALU_OR;
      K_LUI:   return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

  task automatic hold_reset();
    reset = 1'b0;
    im_ready = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    vecs++;
    if ({pc_en, ir_en, RegDst, AluSrc, MemToReg, PCsrc, ExtOp, we, AluOp, memread, memwrite,
         slt_real, halted, bus_err} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got nonzero outputs (pc_en=%b we=%b halted=%b bus_err=%b) want all 0",
               pc_en, we, halted, bus_err);
    end
    vecs++;
    if (instret !== '0) begin errs++; $display("FAIL reset_instret: got %0d want 0", instret); end
    model_instret = 0;
    model_slt = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    im_ready = 1'b1;
    #2;
    vecs++;
    if (ir_en !== 1'b0 || halted !== 1'b0) begin
      errs++;
      $display("FAIL idle_after_reset: got ir_en=%b halted=%b want 0 0", ir_en, halted);
    end
  endtask

  task automatic run_insn(input kind_t k, input int imw, input int mw, input logic [8:0] z, input logic [31:0] word);
    int   cyc, ir_n, rd_n, wr_n, we_n, mcnt;
    logic seen;
    logic [1:0] pcs, rdst, m2r;
    logic [2:0] aop;
    logic ext, asrc;
    cyc = 0; ir_n = 0; rd_n = 0; wr_n = 0; we_n = 0; mcnt = 0; seen = 1'b0;
    pcs = '0; rdst = '0; m2r = '0; aop = '0; ext = 1'b0; asrc = 1'b0;
    instr = word;
    zero = z;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      im_ready = (c > imw);
      mem_ready = 1'b0;
      #1;
      if (memread || memwrite) begin
        mem_ready = (mcnt >= mw);
        mcnt++;
      end
      #1;
      ir_n += int'(ir_en);
      rd_n += int'(memread);
      wr_n += int'(memwrite);
      we_n += int'(we);
      if (pc_en) begin
        seen = 1'b1; cyc = c;
        pcs = PCsrc; rdst = RegDst; m2r = MemToReg; aop = AluOp; ext = ExtOp; asrc = AluSrc;
      end
    end
    vecs++;
    if (!seen || cyc != exp_lat(k, imw, mw)) begin
      errs++;
      $display("FAIL latency %s: got %0d (retired=%b) want %0d", k.name(), cyc, seen, exp_lat(k, imw, mw));
    end
    vecs++;
    if (ir_n != 1) begin errs++; $display("FAIL ir_en_pulses %s: got %0d want 1", k.name(), ir_n); end
    vecs++;
    if (rd_n != ((k == K_LW) ? mw + 1 : 0)) begin
      errs++; $display("FAIL memread_cycles %s: got %0d want %0d", k.name(), rd_n, (k == K_LW) ? mw + 1 : 0);
    end
    vecs++;
    if (wr_n != ((k == K_SW) ? mw + 1 : 0)) begin
      errs++; $display("FAIL memwrite_cycles %s: got %0d want %0d", k.name(), wr_n, (k == K_SW) ? mw + 1 : 0);
    end
    vecs++;
    if (we_n != ((k inside {K_SW, K_BEQ, K_J, K_JR}) ? 0 : 1)) begin
      errs++; $display("FAIL we_pulses %s: got %0d want %0d", k.name(), we_n, (k inside {K_SW, K_BEQ, K_J, K_JR}) ? 0 : 1);
    end
    vecs++;
    if (pcs !== exp_pcsrc(k, z[4])) begin
      errs++; $display("FAIL pcsrc %s: got %b want %b", k.name(), pcs, exp_pcsrc(k, z[4]));
    end
    vecs++;
    if (ext !== (k != K_ORI)) begin errs++; $display("FAIL extop %s: got %b want %b", k.name(), ext, k != K_ORI); end
    if (!(k inside {K_SW, K_BEQ, K_J, K_JR})) begin
      vecs++;
      if (rdst !== exp_regdst(k)) begin
        errs++; $display("FAIL regdst %s: got %b want %b", k.name(), rdst, exp_regdst(k));
      end
      vecs++;
      if (m2r !== exp_m2r(k)) begin
        errs++; $display("FAIL memtoreg %s: got %b want %b", k.name(), m2r, exp_m2r(k));
      end
    end
    if (k inside {K_ADDU, K_SUBU, K_SLT, K_ORI, K_LUI, K_LW, K_SW, K_BEQ}) begin
      vecs++;
      if (asrc !== (k inside {K_ORI, K_LUI, K_LW, K_SW})) begin
        errs++; $display("FAIL alusrc %s: got %b want %b", k.name(), asrc, k inside {K_ORI, K_LUI, K_LW, K_SW});
      end
    end
    if (k inside {K_ADDU, K_SUBU, K_SLT, K_ORI, K_LUI}) begin
      vecs++;
      if (aop !== exp_aluop(k)) begin errs++; $display("FAIL aluop %s: got %0d want %0d", k.name(), aop, exp_aluop(k)); end
    end
    if (seen) model_instret = (model_instret + 1) % (1 << CNT_W);
    if (k == K_SLT) model_slt = z[3];
    @(posedge clk); #1;
    vecs++;
    if (instret !== CNT_W'(model_instret)) begin
      errs++; $display("FAIL instret %s: got %0d want %0d", k.name(), instret, model_instret);
    end
    vecs++;
    if (slt_real !== model_slt) begin
      errs++; $display("FAIL slt_real %s: got %b want %b", k.name(), slt_real, model_slt);
    end
  endtask

  task automatic test_reset();
    hold_reset();
  endtask

  task automatic test_addu();
    run_insn(K_ADDU, 0, 0, 9'($urandom), 32'h00221821);
  endtask

  task automatic test_lw_wait();
    run_insn(K_LW, 0, 3, 9'($urandom), encode(K_LW));
  endtask

  task automatic test_branches();
    run_insn(K_BEQ, 0, 0, 9'h010, encode(K_BEQ));
    run_insn(K_BEQ, 1, 0, 9'h1EF, encode(K_BEQ));
    run_insn(K_JAL, 0, 0, 9'($urandom), encode(K_JAL));
    run_insn(K_SLT, 0, 0, 9'h008, encode(K_SLT));
    run_insn(K_SLT, 2, 0, 9'h1F7, encode(K_SLT));
  endtask

  task automatic test_random();
    kind_t k;
    for (int n = 0; n < 90; n++) begin
      k = kind_t'($urandom_range(10, 0));
      run_insn(k, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 9'($urandom), encode(k));
    end
  endtask

  task automatic test_reset_mid_mem();
    logic found;
    found = 1'b0;
    instr = encode(K_SW);
    im_ready = 1'b1;
    mem_ready = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk); #1;
      found = memwrite;
    end
    vecs++;
    if (!found) begin errs++; $display("FAIL mid_mem_reach: got memwrite=0 want 1 within 10 cycles"); end
    reset = 1'b0;
    #1;
    vecs++;
    if (memwrite !== 1'b0 || pc_en !== 1'b0) begin
      errs++; $display("FAIL async_reset_strobe: got memwrite=%b pc_en=%b want 0 0", memwrite, pc_en);
    end
    vecs++;
    if (instret !== '0) begin errs++; $display("FAIL async_reset_instret: got %0d want 0", instret); end
    hold_reset();
  endtask

  task automatic test_illegal();
    int strobes;
    strobes = 0;
    instr = {6'h3F, 26'($urandom)};
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      im_ready = 1'b1;
      mem_ready = 1'b1;
      #2;
      if (c == 2) begin
        vecs++;
        if (halted !== 1'b0) begin errs++; $display("FAIL illegal_decode: got halted=%b want 0", halted); end
      end
      if (c == 3) begin
        vecs++;
        if (halted !== 1'b1 || bus_err !== 1'b0) begin
          errs++; $display("FAIL illegal_halt: got halted=%b bus_err=%b want 1 0", halted, bus_err);
        end
      end
      if (c >= 3) strobes += int'(pc_en) + int'(ir_en) + int'(we) + int'(memread) + int'(memwrite);
    end
    vecs++;
    if (strobes != 0) begin errs++; $display("FAIL illegal_quiet: got %0d strobes want 0", strobes); end
    vecs++;
    if (instret !== CNT_W'(model_instret)) begin
      errs++; $display("FAIL illegal_instret: got %0d want %0d", instret, model_instret);
    end
    hold_reset();
  endtask

  task automatic test_timeout();
    int strobes;
    strobes = 0;
    instr = encode(K_ADDU);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      im_ready = 1'b0;
      mem_ready = 1'b1;
      #2;
      vecs++;
      if (halted !== (c >= 5)) begin errs++; $display("FAIL timeout_halt c%0d: got %b want %b", c, halted, c >= 5); end
      strobes += int'(pc_en) + int'(ir_en) + int'(we) + int'(memread) + int'(memwrite);
    end
    vecs++;
    if (bus_err !== 1'b1) begin errs++; $display("FAIL timeout_bus_err: got %b want 1", bus_err); end
    vecs++;
    if (strobes != 0) begin errs++; $display("FAIL timeout_quiet: got %0d strobes want 0", strobes); end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_branches();
    test_random();
    test_reset_mid_mem();
    test_illegal();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
